// File: rtl/issue_controller_pkg.sv
// Shared types and defaults for the instruction issue controller.
// The instruction width, default sizing and FSM encoding all live here.
package issue_controller_pkg;

  localparam int INSTRUCTION_WIDTH     = 32;
  localparam int DEFAULT_FIFO_DEPTH    = 4;
  localparam int DEFAULT_START_TIMEOUT = 8;

  typedef logic [INSTRUCTION_WIDTH-1:0] instrWord_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } issueState_t;

endpackage

// File: rtl/issue_controller_if.sv
// Upstream instruction handshake plus core start/busy handshake.
// The controller is the slave; the surrounding system is the master.
interface issue_controller_if;
  import issue_controller_pkg::*;

  logic       instrValid;
  instrWord_t instrIn;
  logic       instrReady;
  logic       flush;
  logic       coreBusy;
  logic       coreStart;
  instrWord_t coreInstruction;

  modport master (
    output instrValid, instrIn, flush, coreBusy,
    input  instrReady, coreStart, coreInstruction
  );

  modport slave (
    input  instrValid, instrIn, flush, coreBusy,
    output instrReady, coreStart, coreInstruction
  );

endinterface

// File: rtl/issue_fifo.sv
// Instruction buffer: power-of-two circular FIFO with flush and a live count.
// The head word is read combinationally so the controller can latch it on pop.
module issue_fifo
  import issue_controller_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           flush,
  input  instrWord_t                     din,
  output instrWord_t                     dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int COUNT_W = $clog2(DEPTH+1);

  instrWord_t       mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             wrEn;
  logic             rdEn;

  assign full  = (count == COUNT_W'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rdPtr];

  // A full buffer still takes a word when the head leaves in the same cycle.
  assign wrEn = push && !flush && (!full || pop);
  assign rdEn = pop && !empty && !flush;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + PTR_W'(1);
      if (rdEn) rdPtr <= rdPtr + PTR_W'(1);
      case ({wrEn, rdEn})
        2'b10:   count <= count + COUNT_W'(1);
        2'b01:   count <= count - COUNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/issue_controller.sv
// Issue controller: buffers instructions and hands them one at a time to the core,
// pulsing coreStart and holding coreInstruction until the core drops coreBusy.
module issue_controller
  import issue_controller_pkg::*;
#(
  parameter int FIFO_DEPTH    = DEFAULT_FIFO_DEPTH,
  parameter int START_TIMEOUT = DEFAULT_START_TIMEOUT
) (
  input  logic                               clk,
  input  logic                               reset,
  issue_controller_if.slave                  bus,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifoCount,
  output logic                               idle,
  output logic                               timeoutError
);

  localparam int TIMER_W = $clog2(START_TIMEOUT+1);

  issueState_t        state;
  issueState_t        nextState;
  logic               pop;
  logic               timeoutHit;
  logic               fifoFull;
  logic               fifoEmpty;
  instrWord_t         fifoHead;
  logic [TIMER_W-1:0] timer;

  issue_fifo #(.DEPTH(FIFO_DEPTH)) fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.instrValid),
    .pop   (pop),
    .flush (bus.flush),
    .din   (bus.instrIn),
    .dout  (fifoHead),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  assign bus.instrReady = !fifoFull;
  assign idle           = (state == IDLE) && fifoEmpty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // NOTE: every output of this block is defaulted first, so no path can infer a latch.
  always_comb begin
    nextState  = state;
    pop        = 1'b0;
    timeoutHit = 1'b0;
    case (state)
      IDLE: begin
        // Flush wins over a pop; coreBusy is deliberately not looked at here.
        if (!fifoEmpty && !bus.flush) begin
          pop       = 1'b1;
          nextState = ISSUE;
        end
      end
      ISSUE:     nextState = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.coreBusy) begin
          nextState = WAIT_DONE;
        end else if (timer == TIMER_W'(START_TIMEOUT-1)) begin
          timeoutHit = 1'b1;
          nextState  = IDLE;
        end
      end
      WAIT_DONE: if (!bus.coreBusy) nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  // Timer counts cycles since the start pulse, so the pulse cycle itself is count 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.coreStart       <= 1'b0;
      bus.coreInstruction <= '0;
      timer               <= '0;
      timeoutError        <= 1'b0;
    end else begin
      bus.coreStart <= pop;
      if (pop) bus.coreInstruction <= fifoHead;
      if (state == ISSUE)          timer <= TIMER_W'(1);
      else if (state == WAIT_BUSY) timer <= timer + TIMER_W'(1);
      if (timeoutHit) timeoutError <= 1'b1;
    end
  end

endmodule
